// File: rtl/router_pkg.sv
// router_pkg: shared defaults, FSM strobe decode and parity helper for the
// router packet register stage.
package router_pkg;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_ADDR_W     = 2;
    localparam int DEF_NUM_PORTS  = 3;
    localparam int DEF_HOLD_DEPTH = 2;
    localparam int PAR_MAX_W      = 32;

    // Decoded FSM strobe, one value per router FSM state that drives this stage
    typedef enum logic [2:0] {
        MODE_IDLE    = 3'd0,
        MODE_RST_INT = 3'd1,
        MODE_DETECT  = 3'd2,
        MODE_LFD     = 3'd3,
        MODE_LOAD    = 3'd4,
        MODE_LAF     = 3'd5,
        MODE_FULL    = 3'd6
    } strobe_mode_e;

    // Running XOR parity accumulate; callers size-cast to their byte width
    function automatic logic [PAR_MAX_W-1:0] xor_parity(
        input logic [PAR_MAX_W-1:0] acc,
        input logic [PAR_MAX_W-1:0] data
    );
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_hold_buf.sv
// router_hold_buf: small synchronous FIFO absorbing bytes while the
// destination FIFO is full. Pointers wrap modulo DEPTH; flags are registered.
module router_hold_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_flush,
    input  logic [DATA_W-1:0] i_din,
    output logic [DATA_W-1:0] o_head,
    output logic              o_full,
    output logic              o_empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nxt;
    logic              r_full;
    logic              r_empty;
    logic              w_do_push;
    logic              w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    // A full buffer still accepts a push when the head leaves in the same cycle
    assign w_do_pop  = i_pop && !r_empty;
    assign w_do_push = i_push && (!r_full || w_do_pop);

    // Next occupancy from push/pop/flush
    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = {CNT_W{1'b0}};
        end else begin
            case ({w_do_push, w_do_pop})
                2'b10:   w_count_nxt = r_count + CNT_W'(1);
                2'b01:   w_count_nxt = r_count - CNT_W'(1);
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage, pointers and registered full/empty flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            r_empty <= (w_count_nxt == {CNT_W{1'b0}});
            if (i_flush) begin
                r_wr_ptr <= {PTR_W{1'b0}};
                r_rd_ptr <= {PTR_W{1'b0}};
            end else begin
                if (w_do_push) begin
                    r_mem[r_wr_ptr] <= i_din;
                    r_wr_ptr        <= ptr_inc(r_wr_ptr);
                end
                if (w_do_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
            end
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_full  = r_full;
    assign o_empty = r_empty;

endmodule

// File: rtl/router_reg_param.sv
// router_reg_param: router packet register stage. Latches and validates the
// header, forwards header/payload bytes to the FIFO write side through a hold
// buffer, and checks XOR parity. Defining ROUTER_REG_LEN_CHK_EN adds the
// payload length check against the length field of the header.
module router_reg_param
    import router_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int NUM_PORTS  = DEF_NUM_PORTS,
    parameter int HOLD_DEPTH = DEF_HOLD_DEPTH
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              pkt_valid,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              rst_int_reg,
    input  logic              detect_add,
    input  logic              lfd_state,
    input  logic              ld_state,
    input  logic              full_state,
    input  logic              laf_state,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              hold_full,
    output logic              hold_empty,
    output logic              parity_done,
    output logic              low_pkt_valid,
    output logic              err,
    output logic              len_err
);
    localparam logic [31:0] NUM_PORTS_U = 32'(NUM_PORTS);

    strobe_mode_e      w_mode;
    logic              w_addr_ok;
    logic              w_is_load;
    logic              w_push;
    logic              w_pop;
    logic              w_drop;
    logic              w_flush;
    logic              w_hold_full;
    logic              w_hold_empty;
    logic [DATA_W-1:0] w_head;

    logic [DATA_W-1:0] r_header;
    logic [DATA_W-1:0] r_int_parity;
    logic [DATA_W-1:0] r_ext_parity;
    logic [DATA_W-1:0] r_dout;
    logic              r_dout_valid;
    logic              r_parity_done;
    logic              r_low_pkt_valid;
    logic              r_err;
`ifdef ROUTER_REG_LEN_CHK_EN
    localparam int LEN_W = DATA_W - ADDR_W;
    logic [LEN_W-1:0]  r_count;
    logic [LEN_W-1:0]  r_len_exp;
    logic              r_len_err;
`endif

    // Collapse the one-hot FSM strobes into a single mode
    always_comb begin
        w_mode = MODE_IDLE;
        if (rst_int_reg) begin
            w_mode = MODE_RST_INT;
        end else if (detect_add) begin
            w_mode = MODE_DETECT;
        end else if (lfd_state) begin
            w_mode = MODE_LFD;
        end else if (ld_state) begin
            w_mode = MODE_LOAD;
        end else if (laf_state) begin
            w_mode = MODE_LAF;
        end else if (full_state) begin
            w_mode = MODE_FULL;
        end else begin
            w_mode = MODE_IDLE;
        end
    end

    assign w_addr_ok = (32'(data_in[ADDR_W-1:0]) < NUM_PORTS_U);
    assign w_is_load = (w_mode == MODE_LOAD);
    assign w_flush   = (w_mode == MODE_RST_INT);
    // Once anything is held, new bytes queue behind it to keep byte order
    assign w_pop  = !w_hold_empty &&
                    ((w_mode == MODE_LAF) || (w_is_load && !fifo_full));
    assign w_push = w_is_load && (fifo_full || !w_hold_empty);
    assign w_drop = w_push && w_hold_full && !w_pop;

    router_hold_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (HOLD_DEPTH)
    ) u_hold_buf (
        .clock   (clock),
        .resetn  (resetn),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .i_din   (data_in),
        .o_head  (w_head),
        .o_full  (w_hold_full),
        .o_empty (w_hold_empty)
    );

    // Header capture, byte forwarding, parity/length tracking and status flags
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_header        <= {DATA_W{1'b0}};
            r_int_parity    <= {DATA_W{1'b0}};
            r_ext_parity    <= {DATA_W{1'b0}};
            r_dout          <= {DATA_W{1'b0}};
            r_dout_valid    <= 1'b0;
            r_parity_done   <= 1'b0;
            r_low_pkt_valid <= 1'b0;
            r_err           <= 1'b0;
`ifdef ROUTER_REG_LEN_CHK_EN
            r_count         <= {LEN_W{1'b0}};
            r_len_exp       <= {LEN_W{1'b0}};
            r_len_err       <= 1'b0;
`endif
        end else begin
            r_dout_valid <= 1'b0;
            // Status checks run the cycle after the parity byte is captured
            if (r_parity_done) begin
                r_err <= r_err | (r_int_parity != r_ext_parity);
`ifdef ROUTER_REG_LEN_CHK_EN
                r_len_err <= (r_count != r_len_exp);
`endif
            end
            case (w_mode)
                MODE_RST_INT: begin
                    r_low_pkt_valid <= 1'b0;
                end
                MODE_DETECT: begin
                    if (pkt_valid && w_addr_ok) begin
                        r_header <= data_in;
`ifdef ROUTER_REG_LEN_CHK_EN
                        r_len_exp <= data_in[DATA_W-1:ADDR_W];
`endif
                    end
                    r_int_parity  <= {DATA_W{1'b0}};
                    r_ext_parity  <= {DATA_W{1'b0}};
                    r_parity_done <= 1'b0;
                    r_err         <= 1'b0;
`ifdef ROUTER_REG_LEN_CHK_EN
                    r_count       <= {LEN_W{1'b0}};
                    r_len_err     <= 1'b0;
`endif
                end
                MODE_LFD: begin
                    r_dout       <= r_header;
                    r_dout_valid <= 1'b1;
                    r_int_parity <= DATA_W'(xor_parity(PAR_MAX_W'(r_int_parity),
                                                       PAR_MAX_W'(r_header)));
                end
                MODE_LOAD: begin
                    if (w_pop) begin
                        r_dout       <= w_head;
                        r_dout_valid <= 1'b1;
                    end else if (!fifo_full) begin
                        r_dout       <= data_in;
                        r_dout_valid <= 1'b1;
                    end
                    if (pkt_valid) begin
                        r_int_parity <= DATA_W'(xor_parity(PAR_MAX_W'(r_int_parity),
                                                           PAR_MAX_W'(data_in)));
`ifdef ROUTER_REG_LEN_CHK_EN
                        if (r_count != {LEN_W{1'b1}}) begin
                            r_count <= r_count + LEN_W'(1);
                        end
`endif
                    end else if (!r_parity_done) begin
                        r_ext_parity    <= data_in;
                        r_parity_done   <= 1'b1;
                        r_low_pkt_valid <= 1'b1;
                    end
                    if (w_drop) begin
                        r_err <= 1'b1;
                    end
                end
                MODE_LAF: begin
                    if (w_pop) begin
                        r_dout       <= w_head;
                        r_dout_valid <= 1'b1;
                    end
                end
                MODE_FULL: begin
                    r_dout_valid <= 1'b0;
                end
                default: begin
                    r_dout_valid <= 1'b0;
                end
            endcase
        end
    end

    assign dout          = r_dout;
    assign dout_valid    = r_dout_valid;
    assign hold_full     = w_hold_full;
    assign hold_empty    = w_hold_empty;
    assign parity_done   = r_parity_done;
    assign low_pkt_valid = r_low_pkt_valid;
    assign err           = r_err;
`ifdef ROUTER_REG_LEN_CHK_EN
    assign len_err       = r_len_err;
`else
    assign len_err       = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg_param.sv
// tb_router_reg_param: randomized and directed packets against a queue-based
// reference of the register stage, plus literal expectations from hand examples.
module tb_router_reg_param;
    localparam int HOLD_DEPTH = 2;
    localparam int NUM_PORTS  = 3;
    localparam logic [5:0] S_IDLE = 6'b000000;
    localparam logic [5:0] S_RST  = 6'b100000;
    localparam logic [5:0] S_DET  = 6'b010000;
    localparam logic [5:0] S_LFD  = 6'b001000;
    localparam logic [5:0] S_LD   = 6'b000100;
    localparam logic [5:0] S_LAF  = 6'b000010;
    localparam logic [5:0] S_FULL = 6'b000001;
`ifdef ROUTER_REG_LEN_CHK_EN
    localparam logic LEN_ON = 1'b1;
`else
    localparam logic LEN_ON = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       rst_int_reg = 1'b0, detect_add = 1'b0, lfd_state = 1'b0;
    logic       ld_state = 1'b0, full_state = 1'b0, laf_state = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, hold_full, hold_empty, parity_done;
    logic       low_pkt_valid, err, len_err;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    // reference model state
    logic [7:0] m_header, m_ip, m_ep, m_dout;
    logic       m_pdone, m_err, m_len_err, m_lpv, m_dv;
    int         m_cnt, m_lexp;
    logic [7:0] m_q[$];

    logic [7:0] got[$];
    logic [7:0] pl_q[$];
    logic [7:0] exp_seq[5] = '{8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D};

    router_reg_param dut (
        .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .rst_int_reg(rst_int_reg), .detect_add(detect_add),
        .lfd_state(lfd_state), .ld_state(ld_state), .full_state(full_state),
        .laf_state(laf_state), .dout(dout), .dout_valid(dout_valid),
        .hold_full(hold_full), .hold_empty(hold_empty), .parity_done(parity_done),
        .low_pkt_valid(low_pkt_valid), .err(err), .len_err(len_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_header = 8'h00; m_ip = 8'h00; m_ep = 8'h00; m_dout = 8'h00;
        m_pdone = 1'b0; m_err = 1'b0; m_len_err = 1'b0; m_lpv = 1'b0; m_dv = 1'b0;
        m_cnt = 0; m_lexp = 0;
        m_q.delete();
    endtask

    // one clock edge of the stage, from the behavioural rules
    task automatic model_step();
        logic [7:0] b;
        b = data_in;
        m_dv = 1'b0;
        if (m_pdone) begin
            if (m_ip != m_ep) m_err = 1'b1;
            if (LEN_ON) m_len_err = (m_cnt != m_lexp);
        end
        if (rst_int_reg) begin
            m_lpv = 1'b0;
            m_q.delete();
        end else if (detect_add) begin
            if (pkt_valid && (int'(b) % 4) < NUM_PORTS) begin
                m_header = b;
                m_lexp = int'(b) / 4;
            end
            m_ip = 8'h00; m_ep = 8'h00; m_pdone = 1'b0;
            m_err = 1'b0; m_len_err = 1'b0; m_cnt = 0;
        end else if (lfd_state) begin
            m_dout = m_header; m_dv = 1'b1; m_ip = m_ip ^ m_header;
        end else if (ld_state) begin
            if (!fifo_full) begin
                if (m_q.size() == 0) m_dout = b;
                else begin
                    m_dout = m_q.pop_front();
                    m_q.push_back(b);
                end
                m_dv = 1'b1;
            end else if (m_q.size() < HOLD_DEPTH) begin
                m_q.push_back(b);
            end else begin
                m_err = 1'b1;
            end
            if (pkt_valid) begin
                m_ip = m_ip ^ b;
                if (m_cnt < 63) m_cnt++;
            end else if (!m_pdone) begin
                m_ep = b; m_pdone = 1'b1; m_lpv = 1'b1;
            end
        end else if (laf_state) begin
            if (m_q.size() > 0) begin
                m_dout = m_q.pop_front(); m_dv = 1'b1;
            end
        end
    endtask

    // every-cycle compare against the model, and capture of forwarded bytes
    always @(negedge clock) begin
        if (resetn && chk_on) begin
            chk("dout", 32'(dout), 32'(m_dout));
            chk("dout_valid", 32'(dout_valid), 32'(m_dv));
            chk("hold_full", 32'(hold_full), 32'(m_q.size() == HOLD_DEPTH));
            chk("hold_empty", 32'(hold_empty), 32'(m_q.size() == 0));
            chk("parity_done", 32'(parity_done), 32'(m_pdone));
            chk("low_pkt_valid", 32'(low_pkt_valid), 32'(m_lpv));
            chk("err", 32'(err), 32'(m_err));
            chk("len_err", 32'(len_err), 32'(m_len_err));
        end
        if (resetn && dout_valid) got.push_back(dout);
    end

    task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
        {rst_int_reg, detect_add, lfd_state, ld_state, laf_state, full_state} = st;
        pkt_valid = pv; data_in = d; fifo_full = ff;
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] par, input int ff_pct);
        cyc(S_DET, 1'b1, hdr, 1'b0);
        cyc(S_LFD, 1'b1, 8'($urandom), 1'b0);
        foreach (pl_q[i]) begin
            while (m_q.size() == HOLD_DEPTH) cyc(S_LAF, 1'b1, 8'($urandom), 1'b0);
            if ($urandom_range(0, 9) == 0) cyc(S_FULL, 1'b1, 8'($urandom), 1'b1);
            cyc(S_LD, 1'b1, pl_q[i], 1'($urandom_range(0, 99) < ff_pct));
        end
        while (m_q.size() == HOLD_DEPTH) cyc(S_LAF, 1'b1, 8'($urandom), 1'b0);
        cyc(S_LD, 1'b0, par, 1'($urandom_range(0, 99) < ff_pct));
        while (m_q.size() > 0) cyc(S_LAF, 1'b0, 8'($urandom), 1'b0);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, 32'(got.size()), 32'd5);
        for (int i = 0; i < 5 && i < got.size(); i++) chk({name, "_byte"}, 32'(got[i]), 32'(exp_seq[i]));
    endtask

    task automatic check_zero_outputs(input string name);
        chk({name, "_dout"}, 32'(dout), 32'd0);
        chk({name, "_dout_valid"}, 32'(dout_valid), 32'd0);
        chk({name, "_hold_full"}, 32'(hold_full), 32'd0);
        chk({name, "_hold_empty"}, 32'(hold_empty), 32'd1);
        chk({name, "_parity_done"}, 32'(parity_done), 32'd0);
        chk({name, "_low_pkt_valid"}, 32'(low_pkt_valid), 32'd0);
        chk({name, "_err"}, 32'(err), 32'd0);
        chk({name, "_len_err"}, 32'(len_err), 32'd0);
    endtask

    initial begin
        logic [7:0] hdr, par;
        int n;
        model_reset();
        repeat (3) @(negedge clock);
        check_zero_outputs("reset");
        resetn = 1'b1;
        chk_on = 1'b1;
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);

        // good packet, FIFO never full
        got.delete();
        pl_q.delete(); pl_q.push_back(8'h11); pl_q.push_back(8'h22); pl_q.push_back(8'h33);
        send_pkt(8'h0D, 8'h0D, 0);
        check_seq("good_pkt");
        chk("good_err", 32'(err), 32'd0);
        chk("good_len_err", 32'(len_err), 32'd0);
        cyc(S_RST, 1'b0, 8'h00, 1'b0);

        // bad parity: parity_done first, err one edge later, held until detect
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        cyc(S_LD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD, 1'b1, 8'h22, 1'b0);
        cyc(S_LD, 1'b1, 8'h33, 1'b0);
        cyc(S_LD, 1'b0, 8'hFF, 1'b0);
        chk("badpar_done", 32'(parity_done), 32'd1);
        chk("badpar_err_early", 32'(err), 32'd0);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        chk("badpar_err", 32'(err), 32'd1);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        chk("badpar_err_hold", 32'(err), 32'd1);

        // invalid address keeps the old header
        cyc(S_DET, 1'b1, 8'h0F, 1'b0);
        chk("badaddr_dv", 32'(dout_valid), 32'd0);
        chk("badaddr_err_clr", 32'(err), 32'd0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        chk("badaddr_hdr", 32'(dout), 32'h0D);
        chk("badaddr_hdr_dv", 32'(dout_valid), 32'd1);
        cyc(S_RST, 1'b0, 8'h00, 1'b0);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);

        // FIFO full while 0x22/0x33 arrive, drained in order by laf
        got.delete();
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        cyc(S_LD, 1'b1, 8'h11, 1'b0);
        cyc(S_LD, 1'b1, 8'h22, 1'b1);
        cyc(S_LD, 1'b1, 8'h33, 1'b1);
        chk("hold_full_lit", 32'(hold_full), 32'd1);
        cyc(S_LAF, 1'b1, 8'h00, 1'b0);
        chk("laf_pop1", 32'(dout), 32'h22);
        cyc(S_LAF, 1'b1, 8'h00, 1'b0);
        chk("laf_pop2", 32'(dout), 32'h33);
        chk("laf_empty", 32'(hold_empty), 32'd1);
        cyc(S_LD, 1'b0, 8'h0D, 1'b0);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        check_seq("hold_pkt");
        chk("hold_pkt_err", 32'(err), 32'd0);
        cyc(S_RST, 1'b0, 8'h00, 1'b0);

        // short packet: length field 3, only 2 payload bytes, correct parity 0x3E
        pl_q.delete(); pl_q.push_back(8'h11); pl_q.push_back(8'h22);
        send_pkt(8'h0D, 8'h3E, 0);
        chk("short_len_err", 32'(len_err), 32'(LEN_ON));
        chk("short_err", 32'(err), 32'd0);
        cyc(S_RST, 1'b0, 8'h00, 1'b0);

        // push into a full hold buffer drops the byte and sets err
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        cyc(S_LD, 1'b1, 8'hAA, 1'b1);
        cyc(S_LD, 1'b1, 8'hBB, 1'b1);
        cyc(S_LD, 1'b1, 8'hCC, 1'b1);
        chk("ovf_err", 32'(err), 32'd1);
        cyc(S_LAF, 1'b1, 8'h00, 1'b0);
        chk("ovf_pop1", 32'(dout), 32'hAA);
        cyc(S_LAF, 1'b1, 8'h00, 1'b0);
        chk("ovf_pop2", 32'(dout), 32'hBB);
        cyc(S_RST, 1'b0, 8'h00, 1'b0);
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);

        // asynchronous reset in the middle of ld_state with a byte held
        cyc(S_DET, 1'b1, 8'h0D, 1'b0);
        cyc(S_LFD, 1'b1, 8'h00, 1'b0);
        cyc(S_LD, 1'b1, 8'h11, 1'b1);
        chk("pre_rst_held", 32'(hold_empty), 32'd0);
        {rst_int_reg, detect_add, lfd_state, ld_state, laf_state, full_state} = S_LD;
        pkt_valid = 1'b1; data_in = 8'h22; fifo_full = 1'b1;
        @(posedge clock);
        model_step();
        #2 resetn = 1'b0;
        model_reset();
        #1 check_zero_outputs("async_rst");
        @(negedge clock);
        {rst_int_reg, detect_add, lfd_state, ld_state, laf_state, full_state} = S_IDLE;
        pkt_valid = 1'b0; fifo_full = 1'b0;
        resetn = 1'b1;
        cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
        got.delete();
        pl_q.delete(); pl_q.push_back(8'h11); pl_q.push_back(8'h22); pl_q.push_back(8'h33);
        send_pkt(8'h0D, 8'h0D, 0);
        check_seq("post_rst");
        chk("post_rst_err", 32'(err), 32'd0);
        cyc(S_RST, 1'b0, 8'h00, 1'b0);

        // randomized packets
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 4) == 0) begin
                cyc(S_DET, 1'b1, {6'($urandom), 2'b11}, 1'b0);
                cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
            end
            hdr = {6'($urandom_range(0, 6)), 2'($urandom_range(0, NUM_PORTS - 1))};
            n = $urandom_range(0, 7);
            par = hdr;
            pl_q.delete();
            for (int i = 0; i < n; i++) begin
                pl_q.push_back(8'($urandom));
                par = par ^ pl_q[i];
            end
            if ($urandom_range(0, 3) == 0) par = 8'($urandom);
            send_pkt(hdr, par, $urandom_range(0, 60));
            cyc(S_RST, 1'b0, 8'h00, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/router_reg_param.md
# router_reg_param

Parametrised packet register stage for the router datapath, sitting between the input port and the destination FIFOs under control of the router FSM. It captures and validates the header and forwards header and payload bytes to the FIFO write side. Bytes that arrive while the FIFO is full are absorbed into a multi-entry hold buffer. It computes and checks XOR parity and, optionally, the payload length declared in the header.

## Interface
- DATA_W, 8, byte width of data_in/dout
- ADDR_W, 2, low header bits carrying destination address; remaining DATA_W-ADDR_W bits carry payload length
- NUM_PORTS, 3, valid destinations are 0..NUM_PORTS-1
- HOLD_DEPTH, 2, hold-buffer entries (>=1)
- clock  in  1  single clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- pkt_valid  in  1  packet byte on data_in; falling edge marks parity byte
- data_in  in  DATA_W  incoming byte
- fifo_full  in  1  selected destination FIFO full
- rst_int_reg, detect_add, lfd_state, ld_state, full_state, laf_state  in  1 each  FSM state strobes
- dout  out  DATA_W  byte to FIFO
- dout_valid  out  1  dout updated this cycle (FIFO write enable qualifier)
- hold_full  out  1  hold buffer at HOLD_DEPTH
- hold_empty  out  1  hold buffer empty
- parity_done, low_pkt_valid, err, len_err  out  1 each  packet status

## Operation
- Header: on detect_add && pkt_valid && data_in[ADDR_W-1:0] < NUM_PORTS, latch header and len_exp = data_in[DATA_W-1:ADDR_W]. If the address is invalid, header is unchanged.
- detect_add clears int_parity, ext_parity, parity_done, err, len_err, payload count.
- lfd_state: dout <= header, dout_valid=1, int_parity ^= header.
- Accepted byte: data_in during ld_state. Payload bytes (pkt_valid=1) XOR into int_parity and increment count; count saturates at 2^(DATA_W-ADDR_W)-1. The first accepted byte with pkt_valid=0 is the parity byte: it sets ext_parity, parity_done and low_pkt_valid.
- Byte routing:
  - ld_state && !fifo_full && hold_empty: dout <= data_in.
  - ld_state && fifo_full: data_in pushed to the hold buffer.
  - laf_state, or ld_state && !fifo_full && !hold_empty: dout <= hold head (pop). Any accepted data_in that cycle is pushed, so ordering is preserved.
- Push into a full hold buffer: the byte is dropped and err is set sticky until detect_add. The FSM must not issue ld_state while hold_full.
- full_state: nothing accepted or popped; dout holds.
- rst_int_reg: clears low_pkt_valid and flushes the hold buffer.
- err: registered one cycle after parity_done as int_parity != ext_parity (or sticky overflow); holds until detect_add.

## Timing
- All outputs registered. resetn low forces all state and outputs to 0 immediately; hold_empty is 1 during reset.
- dout/dout_valid change on the clock edge sampling the strobe (1-cycle latency). dout_valid is 0 on any cycle with no dout update.
- Simultaneous push and pop: occupancy unchanged, head popped first.
- parity_done is set on the edge capturing the parity byte. err/len_err are valid on the next edge.
- Reset mid-packet discards the hold contents and partial parity; no residual state.

## Configuration
- ROUTER_REG_LEN_CHK_EN defined: payload counter present. len_err = (count != len_exp), registered alongside err.
- Undefined: no counter logic; len_err tied 0; len_exp not stored.

## Structure
- router_pkg holds:
  - default parameter values
  - the state strobe encoding shared with the FSM
  - an xor-parity helper function
- Sub-module router_hold_buf: HOLD_DEPTH-entry synchronous FIFO with push/pop/flush, full/empty, and pointers wrapping modulo HOLD_DEPTH.

## Test plan
- Header 0x0D, payload 0x11,0x22,0x33, parity 0x0D, fifo never full -> dout sequence 0x0D,0x11,0x22,0x33,0x0D; err=0, len_err=0.
- Same packet with parity 0xFF -> parity_done=1, then err=1 on the next cycle until the next detect_add.
- detect_add with header 0x0F (addr 3 >= NUM_PORTS) after the previous test -> header stays 0x0D, no dout_valid.
- fifo_full high while 0x22,0x33 arrive -> hold_full=1; after release, laf_state pops 0x22 then 0x33 in order with dout_valid each cycle.
- Header 0x0D (len 3) with only 2 payload bytes -> len_err=1 with ROUTER_REG_LEN_CHK_EN, 0 without.
- resetn low during ld_state with 1 byte held -> all outputs 0 asynchronously; hold_empty=1; next packet forwards cleanly.
